// File: rtl/marker_run_detect_pkg.sv
// Shared definitions for the marker-detect pipeline: compressed colour codes
// (bit0 red, bit1 green, bit2 blue) and the frame report FSM states.
package marker_pkg;

   localparam logic [2:0] COL_BLACK   = 3'b000;
   localparam logic [2:0] COL_RED     = 3'b001;
   localparam logic [2:0] COL_GREEN   = 3'b010;
   localparam logic [2:0] COL_YELLOW  = 3'b011;
   localparam logic [2:0] COL_BLUE    = 3'b100;
   localparam logic [2:0] COL_MAGENTA = 3'b101;
   localparam logic [2:0] COL_CYAN    = 3'b110;
   localparam logic [2:0] COL_WHITE   = 3'b111;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      REPORT = 2'd2
   } state_t;

endpackage

// File: rtl/marker_run_detect_if.sv
// Pixel-in / report-out bundle of marker_run_detect. Defining MARKER_RUN_COUNT_EN
// adds marker_runs_out (qualifying runs per reported frame).
interface marker_run_detect_if #(
   parameter int X_BITS = 11,
   parameter int Y_BITS = 10
);
   import marker_pkg::*;

   // pixel_valid_in qualifies compressed_in and all three strobes. There is no
   // back-pressure: a valid pixel is consumed in the cycle it is presented.
   logic              pixel_valid_in;
   logic [2:0]        compressed_in;
   logic              line_start_in;
   logic              frame_start_in;
   logic              frame_end_in;

   logic              marker_valid_out;
   logic              marker_found_out;
   logic [X_BITS-1:0] marker_x_out;
   logic [Y_BITS-1:0] marker_y_out;
   logic [Y_BITS-1:0] marker_rows_out;
`ifdef MARKER_RUN_COUNT_EN
   logic [15:0]       marker_runs_out;
`endif
   state_t            dbg_state;

   modport master (
      output pixel_valid_in, compressed_in, line_start_in, frame_start_in, frame_end_in,
`ifdef MARKER_RUN_COUNT_EN
      input  marker_runs_out,
`endif
      input  marker_valid_out, marker_found_out, marker_x_out, marker_y_out,
             marker_rows_out, dbg_state
   );

   modport slave (
      input  pixel_valid_in, compressed_in, line_start_in, frame_start_in, frame_end_in,
`ifdef MARKER_RUN_COUNT_EN
      output marker_runs_out,
`endif
      output marker_valid_out, marker_found_out, marker_x_out, marker_y_out,
             marker_rows_out, dbg_state
   );

endinterface

// File: rtl/marker_run_detect_run_length_tracker.sv
// Per-line run-length encoder: x coordinate, current run colour/length/start,
// and a combinational flag telling whether the run closed by this pixel qualifies.
module run_length_tracker
   import marker_pkg::*;
#(
   parameter int         X_BITS        = 11,
   parameter logic [2:0] MARKER_COLOUR = COL_RED,
   parameter int         MIN_RUN       = 4,
   parameter int         MAX_RUN       = 64
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              i_accept,
   input  logic              i_line_start,
   input  logic [2:0]        i_colour,
   output logic [X_BITS-1:0] o_x,
   output logic              o_run_closed,
   output logic              o_qualify,
   output logic [X_BITS-1:0] o_run_start,
   output logic [X_BITS-1:0] o_run_end
);

   localparam int                RUN_W   = $clog2(MAX_RUN + 2);
   localparam logic [RUN_W-1:0]  LEN_SAT = RUN_W'(MAX_RUN + 1);
   localparam logic [RUN_W-1:0]  LEN_MIN = RUN_W'(MIN_RUN);
   localparam logic [RUN_W-1:0]  LEN_MAX = RUN_W'(MAX_RUN);
   localparam logic [X_BITS-1:0] X_MAX   = '1;

   logic [X_BITS-1:0] r_x;
   logic [2:0]        r_run_colour;
   logic [RUN_W-1:0]  r_run_len;
   logic [X_BITS-1:0] r_run_start;

   logic [X_BITS-1:0] w_x;
   logic              w_extend;
   logic              w_colour_ok;
   logic              w_len_ok;

   always_comb begin
      w_x = '0;
      if (!i_line_start) begin
         w_x = (r_x == X_MAX) ? r_x : r_x + 1'b1;
      end
      w_extend     = !i_line_start && (i_colour == r_run_colour);
      w_colour_ok  = (r_run_colour == MARKER_COLOUR);
      w_len_ok     = (r_run_len >= LEN_MIN) && (r_run_len <= LEN_MAX);
      o_run_closed = i_accept && !w_extend;
      // Only a colour change inside the line bounds the run on its right side.
      o_qualify    = o_run_closed && !i_line_start && w_colour_ok && w_len_ok
                     && (r_run_start != '0);
      o_x          = w_x;
      o_run_start  = r_run_start;
      o_run_end    = w_x - 1'b1;
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_x          <= '0;
         r_run_colour <= '0;
         r_run_len    <= '0;
         r_run_start  <= '0;
      end else if (i_accept) begin
         r_x <= w_x;
         if (w_extend) begin
            if (r_run_len != LEN_SAT) begin
               r_run_len <= r_run_len + 1'b1;
            end
         end else begin
            r_run_len    <= RUN_W'(1);
            r_run_start  <= w_x;
            r_run_colour <= i_colour;
         end
      end
   end

endmodule

// File: rtl/marker_run_detect.sv
// Frame-level marker detector: bounding box of qualifying red runs, row count and
// a one-cycle report after frame end. Optional MARKER_RUN_COUNT_EN adds a run counter.
module marker_run_detect
   import marker_pkg::*;
#(
   parameter int         X_BITS        = 11,
   parameter int         Y_BITS        = 10,
   parameter logic [2:0] MARKER_COLOUR = COL_RED,
   parameter int         MIN_RUN       = 4,
   parameter int         MAX_RUN       = 64,
   parameter int         MIN_ROWS      = 2
) (
   input  logic                clk_in,
   input  logic                rst_n_in,
   marker_run_detect_if.slave  bus
);

   localparam logic [Y_BITS-1:0] Y_MAX = '1;

   logic              w_accept;
   logic              w_fs;
   logic              w_ls;
   logic              w_end;
   logic [X_BITS-1:0] w_x;
   logic              w_run_closed;
   logic              w_qualify;
   logic              w_hit;
   logic [X_BITS-1:0] w_run_start;
   logic [X_BITS-1:0] w_run_end;

   state_t            r_state;
   logic [Y_BITS-1:0] r_y;
   logic [X_BITS-1:0] r_min_x;
   logic [X_BITS-1:0] r_max_x;
   logic [Y_BITS-1:0] r_min_y;
   logic [Y_BITS-1:0] r_max_y;
   logic [Y_BITS-1:0] r_rows;
   logic              r_line_hit;

   logic [Y_BITS-1:0] w_y;
   logic [X_BITS-1:0] w_min_x;
   logic [X_BITS-1:0] w_max_x;
   logic [Y_BITS-1:0] w_min_y;
   logic [Y_BITS-1:0] w_max_y;
   logic [Y_BITS-1:0] w_rows;
   logic [Y_BITS-1:0] w_rows_fin;
   logic              w_line_hit;
   logic              w_found;
   logic [X_BITS:0]   w_sum_x;
   logic [Y_BITS:0]   w_sum_y;
   logic [X_BITS-1:0] w_cx;
   logic [Y_BITS-1:0] w_cy;

   logic              r_valid;
   logic              r_found;
   logic [X_BITS-1:0] r_x_out;
   logic [Y_BITS-1:0] r_y_out;
   logic [Y_BITS-1:0] r_rows_out;

`ifdef MARKER_RUN_COUNT_EN
   logic [15:0]       r_runs;
   logic [15:0]       w_runs;
   logic [15:0]       r_runs_out;
`endif

   run_length_tracker #(
      .X_BITS        (X_BITS),
      .MARKER_COLOUR (MARKER_COLOUR),
      .MIN_RUN       (MIN_RUN),
      .MAX_RUN       (MAX_RUN)
   ) u_tracker (
      .clk_in       (clk_in),
      .rst_n_in     (rst_n_in),
      .i_accept     (w_accept),
      .i_line_start (w_ls),
      .i_colour     (bus.compressed_in),
      .o_x          (w_x),
      .o_run_closed (w_run_closed),
      .o_qualify    (w_qualify),
      .o_run_start  (w_run_start),
      .o_run_end    (w_run_end)
   );

   // A frame_start pixel is taken in any state; it also abandons an open frame.
   always_comb begin
      w_fs     = bus.pixel_valid_in && bus.frame_start_in;
      w_accept = bus.pixel_valid_in && (bus.frame_start_in || (r_state == ACTIVE));
      w_ls     = bus.line_start_in || bus.frame_start_in;
      w_end    = w_accept && bus.frame_end_in;
      w_hit    = w_run_closed && w_qualify;
   end

   always_comb begin
      if (w_fs) begin
         w_y        = '0;
         w_min_x    = '1;
         w_max_x    = '0;
         w_min_y    = '1;
         w_max_y    = '0;
         w_rows     = '0;
         w_line_hit = 1'b0;
      end else begin
         w_y        = (w_ls && (r_y != Y_MAX)) ? r_y + 1'b1 : r_y;
         w_min_x    = r_min_x;
         w_max_x    = r_max_x;
         w_min_y    = r_min_y;
         w_max_y    = r_max_y;
         w_rows     = (w_ls && r_line_hit && (r_rows != Y_MAX)) ? r_rows + 1'b1 : r_rows;
         w_line_hit = w_ls ? 1'b0 : r_line_hit;
      end
      if (w_hit) begin
         if (w_run_start < w_min_x) w_min_x = w_run_start;
         if (w_run_end > w_max_x)   w_max_x = w_run_end;
         if (w_y < w_min_y)         w_min_y = w_y;
         if (w_y > w_max_y)         w_max_y = w_y;
         w_line_hit = 1'b1;
      end
      // The last line has no following line start, so its hit is folded in here.
      w_rows_fin = (w_line_hit && (w_rows != Y_MAX)) ? w_rows + 1'b1 : w_rows;
      w_found    = (w_rows_fin >= Y_BITS'(MIN_ROWS));
      w_sum_x    = {1'b0, w_min_x} + {1'b0, w_max_x};
      w_sum_y    = {1'b0, w_min_y} + {1'b0, w_max_y};
      w_cx       = w_found ? X_BITS'(w_sum_x >> 1) : '0;
      w_cy       = w_found ? Y_BITS'(w_sum_y >> 1) : '0;
   end

`ifdef MARKER_RUN_COUNT_EN
   always_comb begin
      w_runs = w_fs ? 16'd0 : r_runs;
      if (w_hit && (w_runs != 16'hFFFF)) begin
         w_runs = w_runs + 16'd1;
      end
   end
`endif

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state    <= IDLE;
         r_y        <= '0;
         r_min_x    <= '0;
         r_max_x    <= '0;
         r_min_y    <= '0;
         r_max_y    <= '0;
         r_rows     <= '0;
         r_line_hit <= 1'b0;
         r_valid    <= 1'b0;
         r_found    <= 1'b0;
         r_x_out    <= '0;
         r_y_out    <= '0;
         r_rows_out <= '0;
`ifdef MARKER_RUN_COUNT_EN
         r_runs     <= '0;
         r_runs_out <= '0;
`endif
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            IDLE, REPORT: begin
               if (w_accept)      r_state <= w_end ? REPORT : ACTIVE;
               else               r_state <= IDLE;
            end
            ACTIVE: begin
               if (w_end)         r_state <= REPORT;
            end
            default:              r_state <= IDLE;
         endcase
         if (w_accept) begin
            r_y        <= w_y;
            r_min_x    <= w_min_x;
            r_max_x    <= w_max_x;
            r_min_y    <= w_min_y;
            r_max_y    <= w_max_y;
            r_rows     <= w_rows;
            r_line_hit <= w_line_hit;
`ifdef MARKER_RUN_COUNT_EN
            r_runs     <= w_runs;
`endif
         end
         if (w_end) begin
            r_valid    <= 1'b1;
            r_found    <= w_found;
            r_x_out    <= w_cx;
            r_y_out    <= w_cy;
            r_rows_out <= w_rows_fin;
`ifdef MARKER_RUN_COUNT_EN
            r_runs_out <= w_runs;
`endif
         end
      end
   end

   assign bus.marker_valid_out = r_valid;
   assign bus.marker_found_out = r_found;
   assign bus.marker_x_out     = r_x_out;
   assign bus.marker_y_out     = r_y_out;
   assign bus.marker_rows_out  = r_rows_out;
   assign bus.dbg_state        = r_state;
`ifdef MARKER_RUN_COUNT_EN
   assign bus.marker_runs_out  = r_runs_out;
`endif

endmodule

// File: doc/marker_run_detect.md
Name: marker_run_detect

Overview:
Consumes the 3-bit thresholded colour stream produced by the marker-detect colour compressor (bit0 = red, bit1 = green, bit2 = blue). It run-length encodes each scanline and keeps runs of a target colour code whose length falls inside a window and that are bounded on both sides by other colours. Per frame it accumulates a bounding box of the qualifying runs. At frame end it reports marker found/centre to the downstream tracker.

Parameters:
X_BITS, 11, width of the pixel x coordinate
Y_BITS, 10, width of the line y coordinate
MARKER_COLOUR, 3'b001, compressed code that counts as marker (red only)
MIN_RUN, 4, minimum qualifying run length in pixels (inclusive)
MAX_RUN, 64, maximum qualifying run length in pixels (inclusive)
MIN_ROWS, 2, minimum number of lines containing a qualifying run for marker_found_out

Ports:
clk_in  in  1  clock; all state on rising edge
rst_n_in  in  1  reset, asynchronous, active-low
pixel_valid_in  in  1  qualifies compressed_in and the three sync strobes
compressed_in  in  3  thresholded colour code of current pixel
line_start_in  in  1  current pixel is first of a line (only sampled with pixel_valid_in)
frame_start_in  in  1  current pixel is first of a frame; implies line start
frame_end_in  in  1  current pixel is last of frame
marker_valid_out  out  1  one-cycle pulse: report fields are updated
marker_found_out  out  1  qualifying rows >= MIN_ROWS
marker_x_out  out  X_BITS  (min_x+max_x)>>1 of bounding box; 0 if not found
marker_y_out  out  Y_BITS  (min_y+max_y)>>1; 0 if not found
marker_rows_out  out  Y_BITS  count of lines with >=1 qualifying run

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM IDLE, all counters/box cleared.
- FSM: IDLE -> ACTIVE on valid pixel with frame_start_in. ACTIVE -> REPORT on valid pixel with frame_end_in. REPORT lasts 1 cycle -> IDLE, or -> ACTIVE if that cycle carries a valid frame_start pixel.
- ACTIVE + frame_start_in: abandon current frame, no report, restart accumulation from this pixel.
- Pixels in IDLE/REPORT without frame_start_in are ignored.
- Coordinates: x = 0 on line-start pixel, else x+1 per valid pixel, saturating at 2^X_BITS-1. y = 0 on frame start, +1 on each subsequent line start, saturating.
- Run tracking: per valid pixel, colour equal to run colour and not line start -> run_len+1. run_len saturates at MAX_RUN+1. Otherwise the run closes, a new run starts (run_len=1, run_start=x, run_colour=compressed_in).
- A closed run qualifies iff: colour == MARKER_COLOUR, MIN_RUN <= run_len <= MAX_RUN, run_start != 0, and it was closed by a different-colour pixel in the same line. Runs closed by line start or open at frame end never qualify.
- On qualification (evaluated combinationally with the closing pixel): min_x/max_x updated with run_start and x-1, min_y/max_y with y, line_hit set.
- rows increments once per line with line_hit. Applied at the next line start, or at frame_end for the final line, including a run closed by the frame_end pixel itself.
- Report latency: marker_valid_out high exactly 1 cycle after the frame_end pixel is accepted. Centre sums computed at X_BITS+1 / Y_BITS+1 bits, then shifted.
- Report fields hold until next report or reset. Accumulators clear at frame start.

Optional Feature:
MARKER_RUN_COUNT_EN: defined -> extra port marker_runs_out (16 bits), total qualifying runs in the reported frame, saturating at 16'hFFFF, updated with marker_valid_out, reset 0. Undefined -> port and counter absent, all other behaviour identical.

Decomposition:
- Package marker_pkg: compressed colour code localparams (COL_RED=3'b001, COL_GREEN=3'b010, COL_BLUE=3'b100, etc.) and the FSM state enum typedef (IDLE, ACTIVE, REPORT), shared with the future tracker.
- Sub-module run_length_tracker: x counter, run colour/length/start, run_closed and qualify outputs.
- Top level: FSM, bounding box, rows, report.

Test Plan:
- 3 lines x16 px, code 001 at x=4..9 elsewhere 000, frame_end on last px -> 1 cycle later valid=1, found=1, x=6, y=1, rows=3.
- Same frame, red run length 3 -> valid=1, found=0, x=0, y=0, rows=0.
- Red at x=0..5, and at x=10..15 (line end), 3 lines -> found=0, rows=0. Also run of 65 px in a 80 px line -> found=0.
- Qualifying run only on line 2, MIN_ROWS=2 -> found=0, rows=1. Also the run closed by the frame_end pixel -> counted, rows=1.
- frame_start mid-frame after qualifying lines, then clean frame with run x=20..29 on lines 5..6 -> single report, x=24, y=5, rows=2. rst_n_in low mid-frame -> outputs 0 immediately.
- MARKER_RUN_COUNT_EN build: two qualifying runs per line, 3 lines -> marker_runs_out=6. Undefined build compiles without the port.
